// File: rtl/i2c_slave_core_if.sv
// Bus bundle for the I2C target engine: pad-side SCL/SDA plus the local
// byte handshake towards the register logic.
interface i2c_slave_core_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       rw;
  logic       busy;

  // The I2C engine itself.
  modport slave (
    input  scl_in, sda_in, tx_data,
    output sda_oe, rx_data, rx_valid, tx_req, rw, busy
  );

  // Pads plus local logic that feeds and consumes the engine.
  modport master (
    output scl_in, sda_in, tx_data,
    input  sda_oe, rx_data, rx_valid, tx_req, rw, busy
  );
endinterface

// File: rtl/i2c_slave_core.sv
// I2C target engine: oversamples SCL/SDA on clk, detects START/STOP,
// matches a fixed 7-bit address, ACKs, and moves bytes to/from local logic.
//
// state     | meaning
// ----------|--------------------------------------------------------------
// IDLE      | bus free or block just reset; waits for START
// ADDR      | shifting in the 7-bit address and R/W bit
// ADDR_ACK  | driving ACK for the matched address during the 9th clock
// WR_DATA   | shifting in a write byte from the master
// WR_ACK    | driving ACK for a received write byte
// RD_DATA   | presenting a read byte on SDA, MSB first
// RD_ACK    | SDA released; sampling the master's ACK/NACK
// WAIT_STOP | not addressed or read ended by NACK; waits for START/STOP
module i2c_slave_core #(
  parameter logic [6:0] SLAVE_ADDR = 7'h55
) (
  input  logic              clk,
  input  logic              rst,
  i2c_slave_core_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t     state;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       ack_phase;

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;
  logic ev_rise, ev_fall, ev_start, ev_stop, sda_q;

  // Two-stage synchronizers plus history; idle-bus reset avoids a false START.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= bus.scl_in;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= bus.sda_in;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  // Registered bus events; sda_q is the SDA level aligned with the event.
  always_ff @(posedge clk) begin
    if (rst) begin
      ev_rise  <= 1'b0;
      ev_fall  <= 1'b0;
      ev_start <= 1'b0;
      ev_stop  <= 1'b0;
      sda_q    <= 1'b1;
    end else begin
      ev_rise  <= scl_s2 & ~scl_d;
      ev_fall  <= ~scl_s2 & scl_d;
      ev_start <= scl_s2 & scl_d & sda_d & ~sda_s2;
      ev_stop  <= scl_s2 & scl_d & ~sda_d & sda_s2;
      sda_q    <= sda_s2;
    end
  end

  // Protocol FSM with registered outputs; START/STOP override every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      shreg        <= 8'h00;
      bit_cnt      <= 3'd0;
      ack_phase    <= 1'b0;
      bus.sda_oe   <= 1'b0;
      bus.rx_data  <= 8'h00;
      bus.rx_valid <= 1'b0;
      bus.tx_req   <= 1'b0;
      bus.rw       <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      bus.rx_valid <= 1'b0;
      bus.tx_req   <= 1'b0;
      if (ev_start) begin
        state      <= ADDR;
        bit_cnt    <= 3'd0;
        ack_phase  <= 1'b0;
        bus.sda_oe <= 1'b0;
        bus.busy   <= 1'b0;
      end else if (ev_stop) begin
        state      <= IDLE;
        ack_phase  <= 1'b0;
        bus.sda_oe <= 1'b0;
        bus.busy   <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (ev_rise) begin
              shreg   <= {shreg[6:0], sda_q};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                // shreg[6:0] already holds the address; sda_q is R/W
                if (shreg[6:0] == SLAVE_ADDR) begin
                  bus.rw    <= sda_q;
                  ack_phase <= 1'b0;
                  state     <= ADDR_ACK;
                end else begin
                  state <= WAIT_STOP;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (ev_fall) begin
              if (!ack_phase) begin
                bus.sda_oe <= 1'b1;
                bus.busy   <= 1'b1;
                ack_phase  <= 1'b1;
              end else begin
                ack_phase  <= 1'b0;
                bit_cnt    <= 3'd0;
                bus.sda_oe <= 1'b0;
                if (bus.rw) begin
                  bus.tx_req <= 1'b1;
                  state      <= RD_DATA;
                end else begin
                  state <= WR_DATA;
                end
              end
            end
          end
          WR_DATA: begin
            if (ev_rise) begin
              shreg   <= {shreg[6:0], sda_q};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                bus.rx_data  <= {shreg[6:0], sda_q};
                bus.rx_valid <= 1'b1;
                ack_phase    <= 1'b0;
                state        <= WR_ACK;
              end
            end
          end
          WR_ACK: begin
            if (ev_fall) begin
              if (!ack_phase) begin
                bus.sda_oe <= 1'b1;
                ack_phase  <= 1'b1;
              end else begin
                bus.sda_oe <= 1'b0;
                ack_phase  <= 1'b0;
                bit_cnt    <= 3'd0;
                state      <= WR_DATA;
              end
            end
          end
          RD_DATA: begin
            // tx_data is captured while tx_req is high, so local logic can
            // present the byte in response to the request cycle itself.
            if (bus.tx_req) begin
              shreg      <= bus.tx_data;
              bus.sda_oe <= ~bus.tx_data[7];
            end else if (ev_fall) begin
              if (bit_cnt == 3'd7) begin
                bus.sda_oe <= 1'b0;
                ack_phase  <= 1'b0;
                state      <= RD_ACK;
              end else begin
                bus.sda_oe <= ~shreg[6];
                shreg      <= {shreg[6:0], 1'b0};
                bit_cnt    <= bit_cnt + 3'd1;
              end
            end
          end
          RD_ACK: begin
            if (ev_rise) begin
              if (sda_q) begin
                bus.busy <= 1'b0;
                state    <= WAIT_STOP;
              end else begin
                ack_phase <= 1'b1;
              end
            end else if (ev_fall && ack_phase) begin
              ack_phase  <= 1'b0;
              bit_cnt    <= 3'd0;
              bus.tx_req <= 1'b1;
              state      <= RD_DATA;
            end
          end
          WAIT_STOP: bus.sda_oe <= 1'b0;
          default:   bus.sda_oe <= 1'b0;
        endcase
      end
    end
  end

endmodule
